// File: rtl/dag_access_sched.sv
// Shares the DAG address port between single program-sequencer accesses and a
// post-modify burst engine. PS has priority; a starvation guard forces burst slots.
module dag_access_sched #(
  parameter int LEN_W      = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ps_req,
  input  logic             ps_dgsclt,
  input  logic             ps_mdfy,
  input  logic [2:0]       ps_iadd,
  input  logic [2:0]       ps_madd,
  output logic             ps_gnt,
  input  logic             bst_start,
  input  logic             bst_abort,
  input  logic             bst_dgsclt,
  input  logic [2:0]       bst_iadd,
  input  logic [2:0]       bst_madd,
  input  logic [LEN_W-1:0] bst_len,
  output logic             bst_busy,
  output logic [LEN_W-1:0] bst_rem,
  output logic             bst_done,
  output logic             bst_err,
  output logic             dg_en,
  output logic             dg_dgsclt,
  output logic             dg_mdfy,
  output logic [2:0]       dg_iadd,
  output logic [2:0]       dg_madd
);

  localparam int ST_W = $clog2(STARVE_LIM + 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STARVE_LIM);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_n;
  logic [LEN_W-1:0] rem_n;
  logic [ST_W-1:0] starve, starve_n;
  logic            lat_dgsclt;
  logic [2:0]      lat_iadd, lat_madd;
  logic            lat_load;
  logic            done_n;
  logic            err_n;
  logic            force_slot;
  logic            ps_win;
  logic            bst_win;

  // Arbitration is purely combinational; the winner's fields register next edge.
  always_comb begin
    force_slot = (state == RUN) && (starve == ST_MAX);
    ps_win     = ps_req && !force_slot;
    bst_win    = (state == RUN) && !ps_win;
    state_n    = state;
    rem_n      = bst_rem;
    starve_n   = starve;
    lat_load   = 1'b0;
    done_n     = 1'b0;
    err_n      = bst_start && ((state == RUN) || (bst_len == '0));
    case (state)
      IDLE: begin
        if (bst_start && (bst_len != '0)) begin
          state_n  = RUN;
          rem_n    = bst_len;
          starve_n = '0;
          lat_load = 1'b1;
        end
      end
      RUN: begin
        if (ps_win) begin
          starve_n = (starve == ST_MAX) ? starve : starve + ST_W'(1);
        end else begin
          starve_n = '0;
          rem_n    = bst_rem - LEN_W'(1);
          if (bst_rem == LEN_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        // An abort still lets this cycle's burst word out but suppresses done.
        if (bst_abort) begin
          state_n  = IDLE;
          rem_n    = '0;
          starve_n = '0;
          done_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ps_gnt   = ps_win && rst_n;
  assign bst_busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      starve <= '0;
      bst_rem <= '0;
      bst_done <= 1'b0;
      bst_err  <= 1'b0;
    end else begin
      state    <= state_n;
      starve   <= starve_n;
      bst_rem  <= rem_n;
      bst_done <= done_n;
      bst_err  <= err_n;
    end
  end

  // Burst address fields are captured once at start and replayed per word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_dgsclt <= 1'b0;
      lat_iadd   <= '0;
      lat_madd   <= '0;
    end else if (lat_load) begin
      lat_dgsclt <= bst_dgsclt;
      lat_iadd   <= bst_iadd;
      lat_madd   <= bst_madd;
    end
  end

  // When nobody wins only dg_en drops; the other fields keep the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dg_en     <= 1'b0;
      dg_dgsclt <= 1'b0;
      dg_mdfy   <= 1'b0;
      dg_iadd   <= '0;
      dg_madd   <= '0;
    end else if (ps_win) begin
      dg_en     <= 1'b1;
      dg_dgsclt <= ps_dgsclt;
      dg_mdfy   <= ps_mdfy;
      dg_iadd   <= ps_iadd;
      dg_madd   <= ps_madd;
    end else if (bst_win) begin
      dg_en     <= 1'b1;
      dg_dgsclt <= lat_dgsclt;
      dg_mdfy   <= 1'b0;
      dg_iadd   <= lat_iadd;
      dg_madd   <= lat_madd;
    end else begin
      dg_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dag_access_sched.sv
// Self-checking bench for dag_access_sched: directed vector table, hand-written
// corner sequences, and randomized traffic checked against a cycle-level model.
module tb_dag_access_sched;

  localparam int LEN_W = 8;
  localparam int LIM   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps_req = 0, ps_dgsclt = 0, ps_mdfy = 0;
  logic [2:0] ps_iadd = 0, ps_madd = 0;
  logic ps_gnt;
  logic bst_start = 0, bst_abort = 0, bst_dgsclt = 0;
  logic [2:0] bst_iadd = 0, bst_madd = 0;
  logic [LEN_W-1:0] bst_len = 0;
  logic bst_busy, bst_done, bst_err;
  logic [LEN_W-1:0] bst_rem;
  logic dg_en, dg_dgsclt, dg_mdfy;
  logic [2:0] dg_iadd, dg_madd;

  dag_access_sched #(.LEN_W(LEN_W), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps_req(ps_req), .ps_dgsclt(ps_dgsclt), .ps_mdfy(ps_mdfy),
    .ps_iadd(ps_iadd), .ps_madd(ps_madd), .ps_gnt(ps_gnt),
    .bst_start(bst_start), .bst_abort(bst_abort), .bst_dgsclt(bst_dgsclt),
    .bst_iadd(bst_iadd), .bst_madd(bst_madd), .bst_len(bst_len),
    .bst_busy(bst_busy), .bst_rem(bst_rem), .bst_done(bst_done), .bst_err(bst_err),
    .dg_en(dg_en), .dg_dgsclt(dg_dgsclt), .dg_mdfy(dg_mdfy),
    .dg_iadd(dg_iadd), .dg_madd(dg_madd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       req, pdg, pmd;
    bit [2:0] pia, pma;
    bit       start, abort, bdg;
    bit [2:0] bia, bma;
    int       len;
  } stim_t;

  typedef struct {
    stim_t    in;
    bit       gnt, en, dg, md;
    bit [2:0] ia, ma;
    bit       busy;
    int       rem;
    bit       done, err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: registered outputs plus scheduler bookkeeping
  bit m_busy; int m_rem; int m_starve; bit m_bdg; bit [2:0] m_bia, m_bma;
  bit m_en, m_dg, m_md; bit [2:0] m_ia, m_ma; bit m_done, m_err;
  bit n_busy; int n_rem; int n_starve; bit n_bdg; bit [2:0] n_bia, n_bma;
  bit n_en, n_dg, n_md; bit [2:0] n_ia, n_ma; bit n_done, n_err;
  bit exp_gnt;

  function automatic stim_t noStim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t psStim(bit dg, bit md, bit [2:0] ia, bit [2:0] ma);
    stim_t s;
    s = noStim();
    s.req = 1; s.pdg = dg; s.pmd = md; s.pia = ia; s.pma = ma;
    return s;
  endfunction

  function automatic stim_t bstStim(bit dg, bit [2:0] ia, bit [2:0] ma, int len);
    stim_t s;
    s = noStim();
    s.start = 1; s.bdg = dg; s.bia = ia; s.bma = ma; s.len = len;
    return s;
  endfunction

  function automatic vec_t mkVec(stim_t s, bit gnt, bit en, bit dg, bit md, bit [2:0] ia,
                                 bit [2:0] ma, bit busy, int rem, bit done, bit err);
    vec_t v;
    v.in = s; v.gnt = gnt; v.en = en; v.dg = dg; v.md = md; v.ia = ia; v.ma = ma;
    v.busy = busy; v.rem = rem; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy = 0; m_rem = 0; m_starve = 0; m_bdg = 0; m_bia = 0; m_bma = 0;
    m_en = 0; m_dg = 0; m_md = 0; m_ia = 0; m_ma = 0; m_done = 0; m_err = 0;
    exp_gnt = 0;
  endtask

  // Drive one cycle's inputs and work out what the scheduler should do with them
  task automatic applyStimulus(input stim_t s);
    bit burst;
    ps_req = s.req; ps_dgsclt = s.pdg; ps_mdfy = s.pmd; ps_iadd = s.pia; ps_madd = s.pma;
    bst_start = s.start; bst_abort = s.abort; bst_dgsclt = s.bdg;
    bst_iadd = s.bia; bst_madd = s.bma; bst_len = LEN_W'(s.len);
    exp_gnt = s.req && !(m_busy && m_starve == LIM);
    burst   = m_busy && !exp_gnt;
    n_busy = m_busy; n_rem = m_rem; n_starve = m_starve;
    n_bdg = m_bdg; n_bia = m_bia; n_bma = m_bma;
    n_en = 0; n_dg = m_dg; n_md = m_md; n_ia = m_ia; n_ma = m_ma;
    if (exp_gnt) begin
      n_en = 1; n_dg = s.pdg; n_md = s.pmd; n_ia = s.pia; n_ma = s.pma;
      if (m_busy) n_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
    end else if (burst) begin
      n_en = 1; n_dg = m_bdg; n_md = 0; n_ia = m_bia; n_ma = m_bma;
      n_starve = 0;
      n_rem = m_rem - 1;
      if (m_rem == 1) n_busy = 0;
    end
    n_done = burst && (m_rem == 1) && !s.abort;
    n_err  = s.start && (m_busy || s.len == 0);
    if (m_busy && s.abort) begin
      n_busy = 0; n_rem = 0; n_starve = 0;
    end
    if (!m_busy && s.start && s.len != 0) begin
      n_busy = 1; n_rem = s.len; n_starve = 0;
      n_bdg = s.bdg; n_bia = s.bia; n_bma = s.bma;
    end
    #2;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_busy = n_busy; m_rem = n_rem; m_starve = n_starve;
    m_bdg = n_bdg; m_bia = n_bia; m_bma = n_bma;
    m_en = n_en; m_dg = n_dg; m_md = n_md; m_ia = n_ia; m_ma = n_ma;
    m_done = n_done; m_err = n_err;
  endtask

  task automatic checkOutput();
    check("ps_gnt", ps_gnt, exp_gnt);
    check("dg_word", {dg_en, dg_dgsclt, dg_mdfy, dg_iadd, dg_madd},
          {m_en, m_dg, m_md, m_ia, m_ma});
    check("bst_busy", bst_busy, m_busy);
    check("bst_rem", bst_rem, m_rem);
    check("bst_done", bst_done, m_done);
    check("bst_err", bst_err, m_err);
  endtask

  task automatic cycle(input stim_t s);
    applyStimulus(s);
    checkOutput();
    advance();
  endtask

  vec_t tbl[11];

  initial begin
    stim_t s;
    bit hold_req;
    stim_t hold_s;
    int guard;

    tbl[0]  = mkVec(psStim(0, 1, 2, 3),      1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkVec(noStim(),                0, 1, 0, 1, 2, 3, 0, 0, 0, 0);
    tbl[2]  = mkVec(bstStim(1, 5, 6, 3),     0, 0, 0, 1, 2, 3, 0, 0, 0, 0);
    tbl[3]  = mkVec(noStim(),                0, 0, 0, 1, 2, 3, 1, 3, 0, 0);
    tbl[4]  = mkVec(noStim(),                0, 1, 1, 0, 5, 6, 1, 2, 0, 0);
    tbl[5]  = mkVec(noStim(),                0, 1, 1, 0, 5, 6, 1, 1, 0, 0);
    tbl[6]  = mkVec(noStim(),                0, 1, 1, 0, 5, 6, 0, 0, 1, 0);
    tbl[7]  = mkVec(noStim(),                0, 0, 1, 0, 5, 6, 0, 0, 0, 0);
    tbl[8]  = mkVec(bstStim(0, 1, 1, 0),     0, 0, 1, 0, 5, 6, 0, 0, 0, 0);
    tbl[9]  = mkVec(noStim(),                0, 0, 1, 0, 5, 6, 0, 0, 0, 1);
    tbl[10] = mkVec(noStim(),                0, 0, 1, 0, 5, 6, 0, 0, 0, 0);

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_dg_en", dg_en, 0);
    check("reset_rem", bst_rem, 0);
    rst_n = 1'b1;
    advance();

    // Single PS access, short burst, zero-length start
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].in);
      check($sformatf("vec%0d_gnt", i), ps_gnt, tbl[i].gnt);
      check($sformatf("vec%0d_word", i), {dg_en, dg_dgsclt, dg_mdfy, dg_iadd, dg_madd},
            {tbl[i].en, tbl[i].dg, tbl[i].md, tbl[i].ia, tbl[i].ma});
      check($sformatf("vec%0d_busy", i), bst_busy, tbl[i].busy);
      check($sformatf("vec%0d_rem", i), bst_rem, tbl[i].rem);
      check($sformatf("vec%0d_done", i), bst_done, tbl[i].done);
      check($sformatf("vec%0d_err", i), bst_err, tbl[i].err);
      advance();
    end

    // Starvation guard: PS held continuously against a 10-word burst
    s = bstStim(0, 3, 4, 10);
    s.req = 1; s.pdg = 1; s.pmd = 1; s.pia = 7; s.pma = 1;
    cycle(s);
    s = psStim(1, 1, 7, 1);
    for (int k = 0; k < 50; k++) begin
      applyStimulus(s);
      check($sformatf("starve_gnt%0d", k), ps_gnt, (k % 5) != 4);
      checkOutput();
      advance();
    end
    check("starve_end_busy", bst_busy, 0);
    check("starve_end_rem", bst_rem, 0);
    cycle(noStim());

    // Start during RUN is rejected and leaves the burst untouched
    cycle(bstStim(1, 2, 2, 4));
    cycle(noStim());
    cycle(bstStim(0, 6, 6, 9));
    applyStimulus(noStim());
    check("runstart_err", bst_err, 1);
    check("runstart_rem", bst_rem, 2);
    checkOutput();
    advance();
    guard = 0;
    while (m_busy && guard < 20) begin cycle(noStim()); guard++; end
    check("runstart_drain", bst_busy, 0);
    cycle(noStim());

    // Abort at rem=4, then a PS request served normally
    cycle(bstStim(1, 4, 5, 8));
    guard = 0;
    while (m_rem != 4 && guard < 20) begin cycle(noStim()); guard++; end
    check("abort_rem4", bst_rem, 4);
    s = noStim(); s.abort = 1;
    cycle(s);
    applyStimulus(noStim());
    check("abort_busy", bst_busy, 0);
    check("abort_rem", bst_rem, 0);
    check("abort_done", bst_done, 0);
    check("abort_last_word", dg_en, 1);
    checkOutput();
    advance();
    applyStimulus(psStim(0, 0, 6, 2));
    check("abort_ps_gnt", ps_gnt, 1);
    advance();
    check("abort_ps_word", {dg_en, dg_mdfy, dg_iadd, dg_madd}, {1'b1, 1'b0, 3'd6, 3'd2});
    cycle(noStim());

    // Asynchronous reset in the middle of a burst
    cycle(bstStim(1, 1, 2, 8));
    guard = 0;
    while (m_rem != 5 && guard < 20) begin cycle(noStim()); guard++; end
    check("rst_pre_rem", bst_rem, 5);
    rst_n = 1'b0;
    #1;
    check("rst_async_all", {ps_gnt, bst_busy, bst_rem, bst_done, bst_err, dg_en,
                            dg_dgsclt, dg_mdfy, dg_iadd, dg_madd}, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(noStim());
      check("rst_after_en", dg_en, 0);
      checkOutput();
      advance();
    end

    // Randomized traffic; a pending PS request is held until granted
    hold_req = 0;
    hold_s = noStim();
    for (int k = 0; k < 400; k++) begin
      if (hold_req) s = hold_s;
      else begin
        s = noStim();
        if ($urandom_range(1, 0) == 1)
          s = psStim(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
      end
      if ($urandom_range(7, 0) == 0) begin
        s.start = 1; s.bdg = 1'($urandom); s.bia = 3'($urandom);
        s.bma = 3'($urandom); s.len = $urandom_range(6, 0);
      end
      s.abort = ($urandom_range(39, 0) == 0);
      applyStimulus(s);
      checkOutput();
      hold_req = s.req && !exp_gnt;
      hold_s = s;
      hold_s.start = 0; hold_s.abort = 0;
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
